vga_scan_timing: RTL
====================

Name: vga_scan_timing

Overview:
- Raster timing generator for the VGA display path.
- Produces HSYNC/VSYNC, the horizontal/vertical active enables (hen, ven) and the active-area pixel coordinates.
- Sits directly upstream of the edge-pulse stage, which is driven with ~(hen&ven), and of the display data processing stage.
- Default timing is 800x600@72 Hz at a 50 MHz pixel rate.

Parameters:
- HSW, 120, hsync width in pixels
- HBP, 64, horizontal back porch
- HEN, 800, horizontal active pixels
- HFP, 56, horizontal front porch
- VSW, 6, vsync width in lines
- VBP, 23, vertical back porch
- VEN, 600, vertical active lines
- VFP, 37, vertical front porch
- HSPOL, 1, hs active level (1 = active-high)
- VSPOL, 1, vs active level
- CW, 12, counter/coordinate width; must satisfy 2^CW >= max(HTOTAL, VTOTAL)

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- pix_en  in  1  pixel tick; counters advance only on clk edges where pix_en=1
- hs  out  1  horizontal sync, level set by HSPOL
- vs  out  1  vertical sync, level set by VSPOL
- hen  out  1  horizontal active window
- ven  out  1  vertical active window
- x  out  CW  active pixel column, 0..HEN-1; 0 outside the active area
- y  out  CW  active line, 0..VEN-1; 0 outside the active area
- line_end  out  1  one-clk pulse on the tick where hcnt wraps HTOTAL-1 -> 0
- frame_start  out  1  one-clk pulse on the tick where (hcnt,vcnt) wraps (HTOTAL-1,VTOTAL-1) -> (0,0)

Behaviour:
- Totals: HTOTAL = HSW+HBP+HEN+HFP (1040 by default); VTOTAL = VSW+VBP+VEN+VFP (666 by default).
- Line order: sync, back porch, active, front porch. Frame order is the same in lines.
- Clocking: single clock, clk; rstn is asynchronous assert, synchronous deassert handled upstream. All outputs are registers.
- hcnt:
  - On a clk edge with pix_en=1: hcnt = (hcnt==HTOTAL-1) ? 0 : hcnt+1.
  - With pix_en=0: hcnt and all outputs hold.
- vcnt: increments only on enabled edges where hcnt wraps; wraps VTOTAL-1 -> 0 on that same edge.
- Output decode: outputs are loaded from the decode of the NEW counter values, so outputs and counters are always consistent with zero lag.
  - hs = HSPOL when hcnt < HSW, else ~HSPOL.
  - vs = VSPOL when vcnt < VSW, else ~VSPOL.
  - hen = 1 when HSW+HBP <= hcnt < HSW+HBP+HEN.
  - ven = 1 when VSW+VBP <= vcnt < VSW+VBP+VEN.
  - x = hcnt-(HSW+HBP) when hen=1, else 0. y = vcnt-(VSW+VBP) when ven=1, else 0. Both are truncated to CW bits.
- Pulses:
  - line_end and frame_start are high for exactly one clk after the qualifying enabled edge, then low, even if pix_en stays 0.
  - frame_start implies line_end in the same cycle.
- Reset (rstn=0): immediately, mid-line or mid-frame:
  - hcnt=vcnt=0.
  - hs=HSPOL, vs=VSPOL.
  - hen=ven=0, x=y=0.
  - line_end=frame_start=0.
  - No frame_start pulse is emitted on reset release; the first pulse comes at the first natural frame wrap.
- pix_en held high permanently gives one pixel per clk.

Decomposition:
- Package vga_timing_pkg holds:
  - The default 800x600@72 constants (HSW..VFP).
  - HTOTAL/VTOTAL computation as a constant function.
  - A 640x480@60 alternative set.
- Sub-module scan_counter (parameters MAX, CW):
  - Wrap counter with inc input and wrap output.
  - Instantiated twice. Horizontal: inc=pix_en. Vertical: inc=pix_en & h_wrap.

Test Plan:
- Reset, then hold pix_en=0 for 10 clk -> hs=1, vs=1, hen=ven=0, x=y=0, no pulses.
- pix_en=1 for one line -> hs high for exactly 120 clk; hen high for 800 clk starting at hcnt=184; x runs 0..799 in step with hen; line_end pulses once at clk 1040.
- Full frame with pix_en=1 -> frame_start period 692640 clk; vs high for 6 lines = 6240 clk; ven high for 600 lines; y runs 0..599; 600 hen windows occur while ven=1.
- pix_en toggling 1,0,1,0 -> hs width 240 clk; outputs hold on pix_en=0 cycles; line_end stays 1 clk wide.
- Assert rstn=0 at hcnt=500, vcnt=300 -> outputs reach reset values without waiting for a clk edge; after release, counting resumes from (0,0) and the first frame_start comes 692640 ticks later.
- Re-run with HSPOL=0, VSPOL=0 and the 640x480 package set -> hs/vs inverted; HTOTAL=800, VTOTAL=525.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Raster timing constants shared by the VGA scan path: the default
// 800x600@72 set, a 640x480@60 alternative and the total-length helper.
package vga_timing_pkg;

  // 800x600 @ 72 Hz, 50 MHz pixel rate
  localparam int unsigned SVGA_HSW = 120;
  localparam int unsigned SVGA_HBP = 64;
  localparam int unsigned SVGA_HEN = 800;
  localparam int unsigned SVGA_HFP = 56;
  localparam int unsigned SVGA_VSW = 6;
  localparam int unsigned SVGA_VBP = 23;
  localparam int unsigned SVGA_VEN = 600;
  localparam int unsigned SVGA_VFP = 37;

  // 640x480 @ 60 Hz
  localparam int unsigned VGA_HSW = 96;
  localparam int unsigned VGA_HBP = 48;
  localparam int unsigned VGA_HEN = 640;
  localparam int unsigned VGA_HFP = 16;
  localparam int unsigned VGA_VSW = 2;
  localparam int unsigned VGA_VBP = 33;
  localparam int unsigned VGA_VEN = 480;
  localparam int unsigned VGA_VFP = 10;

  // Length of one line (in pixels) or one frame (in lines)
  function automatic int unsigned scan_total(input int unsigned sw, input int unsigned bp,
                                             input int unsigned en, input int unsigned fp);
    return sw + bp + en + fp;
  endfunction

  localparam int unsigned SVGA_HTOTAL = scan_total(SVGA_HSW, SVGA_HBP, SVGA_HEN, SVGA_HFP);
  localparam int unsigned SVGA_VTOTAL = scan_total(SVGA_VSW, SVGA_VBP, SVGA_VEN, SVGA_VFP);
  localparam int unsigned VGA_HTOTAL  = scan_total(VGA_HSW, VGA_HBP, VGA_HEN, VGA_HFP);
  localparam int unsigned VGA_VTOTAL  = scan_total(VGA_VSW, VGA_VBP, VGA_VEN, VGA_VFP);

endpackage

// File: rtl/vga_scan_timing_if.sv
// Raster timing bus: pixel tick in, sync/enable/coordinate/pulse outputs.
interface vga_scan_timing_if #(
  parameter int unsigned CW = 12
);
  logic          pix_en;
  logic          hs;
  logic          vs;
  logic          hen;
  logic          ven;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          line_end;
  logic          frame_start;

  modport master (
    input  pix_en,
    output hs, vs, hen, ven, x, y, line_end, frame_start
  );

  modport slave (
    output pix_en,
    input  hs, vs, hen, ven, x, y, line_end, frame_start
  );
endinterface

// File: rtl/scan_counter.sv
// Wrap counter 0..MAX-1. Exposes the value it will hold after this edge so
// the parent can register a decode that is aligned with the count.
module scan_counter #(
  parameter int unsigned MAX = 1040,
  parameter int unsigned CW  = 12
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_inc,
  output logic [CW-1:0] o_cnt_nxt,
  output logic          o_wrap
);

  localparam logic [CW-1:0] LAST = CW'(MAX - 1);

  logic [CW-1:0] r_cnt;

  // Next count and wrap flag; wrap only asserts on an advancing edge
  always_comb begin
    o_wrap    = 1'b0;
    o_cnt_nxt = r_cnt;
    if (i_inc) begin
      if (r_cnt == LAST) begin
        o_wrap    = 1'b1;
        o_cnt_nxt = '0;
      end else begin
        o_cnt_nxt = r_cnt + CW'(1);
      end
    end else begin
      o_cnt_nxt = r_cnt;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= o_cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_scan_timing.sv
// Raster timing generator: horizontal and vertical wrap counters with a
// registered decode of the *next* counts, so every output matches the
// counters with no pipeline lag.
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned HSW   = SVGA_HSW,
  parameter int unsigned HBP   = SVGA_HBP,
  parameter int unsigned HEN   = SVGA_HEN,
  parameter int unsigned HFP   = SVGA_HFP,
  parameter int unsigned VSW   = SVGA_VSW,
  parameter int unsigned VBP   = SVGA_VBP,
  parameter int unsigned VEN   = SVGA_VEN,
  parameter int unsigned VFP   = SVGA_VFP,
  parameter bit          HSPOL = 1'b1,
  parameter bit          VSPOL = 1'b1,
  parameter int unsigned CW    = 12
) (
  input  logic              clk,
  input  logic              rstn,
  vga_scan_timing_if.master bus
);

  localparam int unsigned HTOTAL = scan_total(HSW, HBP, HEN, HFP);
  localparam int unsigned VTOTAL = scan_total(VSW, VBP, VEN, VFP);

  localparam logic [CW-1:0] H_SYNC_END  = CW'(HSW);
  localparam logic [CW-1:0] H_ACT_START = CW'(HSW + HBP);
  localparam logic [CW-1:0] H_ACT_END   = CW'(HSW + HBP + HEN);
  localparam logic [CW-1:0] V_SYNC_END  = CW'(VSW);
  localparam logic [CW-1:0] V_ACT_START = CW'(VSW + VBP);
  localparam logic [CW-1:0] V_ACT_END   = CW'(VSW + VBP + VEN);

  logic [CW-1:0] w_hnxt;
  logic [CW-1:0] w_vnxt;
  logic          w_hwrap;
  logic          w_vwrap;
  logic          w_vinc;
  logic          w_hs;
  logic          w_vs;
  logic          w_hen;
  logic          w_ven;
  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;

  logic          r_hs;
  logic          r_vs;
  logic          r_hen;
  logic          r_ven;
  logic [CW-1:0] r_x;
  logic [CW-1:0] r_y;
  logic          r_line_end;
  logic          r_frame_start;

  // A line is finished only on a pixel tick that wraps the column counter
  assign w_vinc = bus.pix_en & w_hwrap;

  scan_counter #(.MAX(HTOTAL), .CW(CW)) u_hcnt (
    .clk       (clk),
    .rstn      (rstn),
    .i_inc     (bus.pix_en),
    .o_cnt_nxt (w_hnxt),
    .o_wrap    (w_hwrap)
  );

  scan_counter #(.MAX(VTOTAL), .CW(CW)) u_vcnt (
    .clk       (clk),
    .rstn      (rstn),
    .i_inc     (w_vinc),
    .o_cnt_nxt (w_vnxt),
    .o_wrap    (w_vwrap)
  );

  // Decode sync levels, active windows and active-area coordinates from next counts
  always_comb begin
    w_hs  = HSPOL;
    w_vs  = VSPOL;
    w_hen = 1'b0;
    w_ven = 1'b0;
    w_x   = '0;
    w_y   = '0;
    if (w_hnxt < H_SYNC_END) begin
      w_hs = HSPOL;
    end else begin
      w_hs = ~HSPOL;
    end
    if (w_vnxt < V_SYNC_END) begin
      w_vs = VSPOL;
    end else begin
      w_vs = ~VSPOL;
    end
    if ((w_hnxt >= H_ACT_START) && (w_hnxt < H_ACT_END)) begin
      w_hen = 1'b1;
      w_x   = w_hnxt - H_ACT_START;
    end else begin
      w_hen = 1'b0;
      w_x   = '0;
    end
    if ((w_vnxt >= V_ACT_START) && (w_vnxt < V_ACT_END)) begin
      w_ven = 1'b1;
      w_y   = w_vnxt - V_ACT_START;
    end else begin
      w_ven = 1'b0;
      w_y   = '0;
    end
  end

  // Output registers: load on pixel ticks, pulses drop on any non-tick clk
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hs          <= HSPOL;
      r_vs          <= VSPOL;
      r_hen         <= 1'b0;
      r_ven         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_end    <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (bus.pix_en) begin
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_hen         <= w_hen;
      r_ven         <= w_ven;
      r_x           <= w_x;
      r_y           <= w_y;
      r_line_end    <= w_hwrap;
      r_frame_start <= w_hwrap & w_vwrap;
    end else begin
      r_line_end    <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign bus.hs          = r_hs;
  assign bus.vs          = r_vs;
  assign bus.hen         = r_hen;
  assign bus.ven         = r_ven;
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.line_end    = r_line_end;
  assign bus.frame_start = r_frame_start;

endmodule
